// File: rtl/pattern_pkg.sv
// Shared definitions for the programmable serial pattern detector:
// state-width helper and the prefix/suffix fallback function.
package pattern_pkg;

    // Widest pattern the detector supports; sizes the fallback search.
    localparam int PAT_MAX   = 16;
    localparam int PAT_IDX_W = 4;

    // Bits needed to hold a match length in 0..width.
    function automatic int st_width(input int width);
        return $clog2(width + 1);
    endfunction

    // Given that the last `st` consumed bits equal the first `st` bits of the
    // pattern, and bit `a` arrives next, return the length of the longest
    // suffix of (matched prefix, a) that is also a pattern prefix, capped at
    // `width`. With st == width this is the overlapping restart point.
    // The pattern is right-aligned: bit width-1 is the first bit received.
    function automatic int pat_next(
        input int                 st,
        input logic               a,
        input logic [PAT_MAX-1:0] pattern,
        input int                 width
    );
        int   best;
        int   idx;
        logic ok;
        best = 0;
        for (int k = 1; k <= PAT_MAX; k++) begin
            if (k <= width && k <= st + 1) begin
                ok = 1'b1;
                for (int i = 0; i < PAT_MAX; i++) begin
                    if (i < k) begin
                        // idx walks the candidate suffix; idx == st is the new bit.
                        idx = st + 1 - k + i;
                        if (idx == st) begin
                            if (a != pattern[PAT_IDX_W'(width - 1 - i)]) ok = 1'b0;
                        end else begin
                            if (pattern[PAT_IDX_W'(width - 1 - idx)] !=
                                pattern[PAT_IDX_W'(width - 1 - i)]) ok = 1'b0;
                        end
                    end
                end
                if (ok) best = k;
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/pattern_detector_next_state.sv
// Combinational next-match-length logic for the pattern detector.
// Handles the advance, the fallback, and the non-overlapping restart.
module pattern_next_state
    import pattern_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int SW    = st_width(WIDTH)
) (
    input  logic [SW-1:0]    i_st,
    input  logic             i_a,
    input  logic [WIDTH-1:0] i_pattern,
    input  logic             i_overlap,
    output logic [SW-1:0]    o_st_next
);

    localparam logic [SW-1:0] ST_FULL = SW'(WIDTH);

    logic [PAT_MAX-1:0] w_pattern_ext;
    logic [SW-1:0]      w_st_eff;

    assign w_pattern_ext = PAT_MAX'(i_pattern);

    // Without overlap a completed match starts the search from scratch.
    assign w_st_eff = (i_st == ST_FULL && !i_overlap) ? '0 : i_st;

    // Longest suffix of (matched prefix, new bit) that is a pattern prefix.
    always_comb begin
        o_st_next = SW'(pat_next(int'(w_st_eff), i_a, w_pattern_ext, WIDTH));
    end

endmodule

// File: rtl/pattern_detector.sv
// Programmable Moore serial pattern detector with overlap control and a
// saturating, clearable match counter. y and count come straight from
// registers, so there is no combinational input-to-output path.
module pattern_detector
    import pattern_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int CNT_W = 8,
    localparam int SW    = st_width(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             a,
    input  logic             load,
    input  logic [WIDTH-1:0] pattern,
    input  logic             overlap,
    input  logic             clr_count,
    output logic             y,
    output logic [CNT_W-1:0] count,
    output logic [SW-1:0]    o_dbg_st
);

    localparam logic [SW-1:0]    ST_FULL = SW'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] r_pattern_q;
    logic [SW-1:0]    r_st;
    logic [CNT_W-1:0] r_count;
    logic [SW-1:0]    w_st_next;
    logic             w_hit;

    pattern_next_state #(
        .WIDTH (WIDTH)
    ) u_next (
        .i_st      (r_st),
        .i_a       (a),
        .i_pattern (r_pattern_q),
        .i_overlap (overlap),
        .o_st_next (w_st_next)
    );

    // A consumed bit that lands on a full match; load discards the bit.
    assign w_hit = en && !load && (w_st_next == ST_FULL);

    // Pattern latch and match-length state; load beats en and restarts search.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pattern_q <= '0;
            r_st        <= '0;
        end else if (load) begin
            r_pattern_q <= pattern;
            r_st        <= '0;
        end else if (en) begin
            r_st        <= w_st_next;
        end
    end

    // Saturating match counter; clear wins over a same-cycle match.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clr_count) begin
            r_count <= '0;
        end else if (w_hit && r_count != CNT_MAX) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign y        = (r_st == ST_FULL);
    assign count    = r_count;
    assign o_dbg_st = r_st;

endmodule

// File: tb/tb_pattern_detector.sv
// Bench for pattern_detector: a directed vector table, hand-written
// saturation and asynchronous-reset sequences, then a long random run
// against a brute-force bit-history model and a legacy 01 detector model.
module tb_pattern_detector;

    logic       clk;
    logic       reset_n;
    logic       en;
    logic       a;
    logic       load;
    logic [3:0] pattern4;
    logic [1:0] pattern2;
    logic       overlap;
    logic       ov_leg;
    logic       clr_count;

    logic       y4;
    logic [7:0] cnt4;
    logic [2:0] st4;
    logic       ys;
    logic [1:0] cnts;
    logic [2:0] sts;
    logic       yl;
    logic [7:0] cntl;
    logic [1:0] stl;

    int n_checks;
    int n_fail;

    // Reference model state: history of consumed bits (bit 0 newest).
    logic [3:0]  m_pat;
    logic [15:0] m_hist;
    int          m_hlen;
    int          m_cnt4;
    int          m_cnts;
    logic [1:0]  l_last;
    int          l_n;
    int          l_cnt;

    typedef struct {
        logic [3:0] pat;
        logic       ld;
        logic       e;
        logic       b;
        logic       ov;
        logic       clr;
        int         est;
        int         ey;
        int         ecnt;
    } vec_t;

    vec_t vecs[$];

    pattern_detector #(.WIDTH(4), .CNT_W(8)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .en(en), .a(a), .load(load),
        .pattern(pattern4), .overlap(overlap), .clr_count(clr_count),
        .y(y4), .count(cnt4), .o_dbg_st(st4)
    );

    pattern_detector #(.WIDTH(4), .CNT_W(2)) u_sat (
        .clk(clk), .reset_n(reset_n), .en(en), .a(a), .load(load),
        .pattern(pattern4), .overlap(overlap), .clr_count(clr_count),
        .y(ys), .count(cnts), .o_dbg_st(sts)
    );

    pattern_detector #(.WIDTH(2), .CNT_W(8)) u_leg (
        .clk(clk), .reset_n(reset_n), .en(en), .a(a), .load(load),
        .pattern(pattern2), .overlap(ov_leg), .clr_count(clr_count),
        .y(yl), .count(cntl), .o_dbg_st(stl)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Longest suffix (up to 4 bits) of the history equal to a pattern prefix.
    function automatic int ref_st(input logic [15:0] hist, input int hlen,
                                  input logic [3:0] pat);
        logic ok;
        for (int k = 4; k >= 1; k--) begin
            if (k <= hlen) begin
                ok = 1'b1;
                for (int i = 0; i < k; i++)
                    if (hist[k-1-i] != pat[3-i]) ok = 1'b0;
                if (ok) return k;
            end
        end
        return 0;
    endfunction

    function automatic int leg_y();
        return (l_n == 2 && l_last == 2'b01) ? 1 : 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pat  = '0;
        m_hist = '0;
        m_hlen = 0;
        m_cnt4 = 0;
        m_cnts = 0;
        l_last = '0;
        l_n    = 0;
        l_cnt  = 0;
    endtask

    // Drive one cycle from a negedge, advance the models, land on next negedge.
    task automatic cyc(input logic [3:0] p, input logic ld, input logic e,
                       input logic b, input logic ov, input logic clr);
        logic hit4;
        logic hitl;
        hit4 = 1'b0;
        hitl = 1'b0;
        pattern4  = p;
        load      = ld;
        en        = e;
        a         = b;
        overlap   = ov;
        clr_count = clr;
        if (ld) begin
            m_pat  = p;
            m_hist = '0;
            m_hlen = 0;
            l_last = '0;
            l_n    = 0;
        end else if (e) begin
            if (ref_st(m_hist, m_hlen, m_pat) == 4 && !ov) begin
                m_hist = '0;
                m_hlen = 0;
            end
            m_hist = {m_hist[14:0], b};
            if (m_hlen < 16) m_hlen++;
            hit4 = (ref_st(m_hist, m_hlen, m_pat) == 4);
            l_last = {l_last[0], b};
            if (l_n < 2) l_n++;
            hitl = (leg_y() == 1);
        end
        if (clr) begin
            m_cnt4 = 0;
            m_cnts = 0;
            l_cnt  = 0;
        end else begin
            if (hit4 && m_cnt4 < 255) m_cnt4++;
            if (hit4 && m_cnts < 3)   m_cnts++;
            if (hitl && l_cnt < 255)  l_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic add(input logic [3:0] p, input logic ld, input logic e,
                       input logic b, input logic ov, input logic clr,
                       input int est, input int ey, input int ecnt);
        vec_t v;
        v.pat = p; v.ld = ld; v.e = e; v.b = b; v.ov = ov; v.clr = clr;
        v.est = est; v.ey = ey; v.ecnt = ecnt;
        vecs.push_back(v);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        {en, a, load, overlap, clr_count} = '0;
        pattern4 = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [3:0] rp;
        logic       ov_r;
        n_checks = 0;
        n_fail   = 0;
        pattern2 = 2'b01;
        ov_leg   = 1'b1;
        reset_n  = 1'b0;
        {en, a, load, overlap, clr_count} = '0;
        pattern4 = '0;
        model_reset();

        // Reset state
        @(negedge clk);
        chk("reset_y", int'(y4), 0);
        chk("reset_cnt", int'(cnt4), 0);
        chk("reset_st", int'(st4), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed vector table: pat, ld, en, a, ov, clr -> st, y, count
        add(4'b1011, 1, 0, 0, 1, 0, 0, 0, 0);
        // overlap stream 1,0,1,1,0,1,1
        add(4'b0101, 0, 1, 1, 1, 0, 1, 0, 0);
        add(4'b0101, 0, 1, 0, 1, 0, 2, 0, 0);
        add(4'b0101, 0, 1, 1, 1, 0, 3, 0, 0);
        add(4'b0101, 0, 1, 1, 1, 0, 4, 1, 1);
        add(4'b0101, 0, 1, 0, 1, 0, 2, 0, 1);
        add(4'b0101, 0, 1, 1, 1, 0, 3, 0, 1);
        add(4'b0101, 0, 1, 1, 1, 0, 4, 1, 2);
        add(4'b0101, 0, 0, 0, 1, 1, 4, 1, 0);
        add(4'b0101, 0, 0, 1, 1, 0, 4, 1, 0);
        // non-overlap stream 1,0,1,1,0,1,1
        add(4'b1011, 1, 0, 0, 0, 0, 0, 0, 0);
        add(4'b0101, 0, 1, 1, 0, 0, 1, 0, 0);
        add(4'b0101, 0, 1, 0, 0, 0, 2, 0, 0);
        add(4'b0101, 0, 1, 1, 0, 0, 3, 0, 0);
        add(4'b0101, 0, 1, 1, 0, 0, 4, 1, 1);
        add(4'b0101, 0, 1, 0, 0, 0, 0, 0, 1);
        add(4'b0101, 0, 1, 1, 0, 0, 1, 0, 1);
        add(4'b0101, 0, 1, 1, 0, 0, 1, 0, 1);
        // 1,0,1,1 with three idle cycles between bits
        add(4'b1011, 1, 0, 0, 1, 0, 0, 0, 1);
        add(4'b0101, 0, 1, 1, 1, 0, 1, 0, 1);
        add(4'b0101, 0, 0, 0, 1, 0, 1, 0, 1);
        add(4'b0101, 0, 0, 1, 1, 0, 1, 0, 1);
        add(4'b0101, 0, 0, 0, 1, 0, 1, 0, 1);
        add(4'b0101, 0, 1, 0, 1, 0, 2, 0, 1);
        add(4'b0101, 0, 0, 1, 1, 0, 2, 0, 1);
        add(4'b0101, 0, 0, 0, 1, 0, 2, 0, 1);
        add(4'b0101, 0, 0, 1, 1, 0, 2, 0, 1);
        add(4'b0101, 0, 1, 1, 1, 0, 3, 0, 1);
        add(4'b0101, 0, 0, 0, 1, 0, 3, 0, 1);
        add(4'b0101, 0, 0, 0, 1, 0, 3, 0, 1);
        add(4'b0101, 0, 0, 0, 1, 0, 3, 0, 1);
        add(4'b0101, 0, 1, 1, 1, 0, 4, 1, 2);
        add(4'b0101, 0, 0, 0, 1, 0, 4, 1, 2);
        add(4'b0101, 0, 0, 1, 1, 0, 4, 1, 2);
        add(4'b0101, 0, 0, 0, 1, 0, 4, 1, 2);
        add(4'b0101, 0, 1, 1, 1, 0, 1, 0, 2);
        // load together with en after 1,0,1 discards the bit
        add(4'b1011, 1, 0, 0, 1, 0, 0, 0, 2);
        add(4'b0101, 0, 1, 1, 1, 0, 1, 0, 2);
        add(4'b0101, 0, 1, 0, 1, 0, 2, 0, 2);
        add(4'b0101, 0, 1, 1, 1, 0, 3, 0, 2);
        add(4'b1011, 1, 1, 1, 1, 0, 0, 0, 2);
        add(4'b0101, 0, 1, 0, 1, 0, 0, 0, 2);
        add(4'b0101, 0, 1, 1, 1, 0, 1, 0, 2);
        add(4'b0101, 0, 1, 0, 1, 0, 2, 0, 2);
        add(4'b0101, 0, 1, 1, 1, 0, 3, 0, 2);
        add(4'b0101, 0, 1, 1, 1, 0, 4, 1, 3);
        // new pattern 0110 and an overlapping re-match
        add(4'b0110, 1, 0, 0, 1, 0, 0, 0, 3);
        add(4'b1001, 0, 1, 0, 1, 0, 1, 0, 3);
        add(4'b1001, 0, 1, 1, 1, 0, 2, 0, 3);
        add(4'b1001, 0, 1, 1, 1, 0, 3, 0, 3);
        add(4'b1001, 0, 1, 0, 1, 0, 4, 1, 4);
        add(4'b1001, 0, 1, 1, 1, 0, 2, 0, 4);
        add(4'b1001, 0, 1, 1, 1, 0, 3, 0, 4);
        add(4'b1001, 0, 1, 0, 1, 0, 4, 1, 5);

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].pat, vecs[i].ld, vecs[i].e, vecs[i].b, vecs[i].ov, vecs[i].clr);
            chk($sformatf("vec%0d_st", i), int'(st4), vecs[i].est);
            chk($sformatf("vec%0d_y", i), int'(y4), vecs[i].ey);
            chk($sformatf("vec%0d_cnt", i), int'(cnt4), vecs[i].ecnt);
        end

        // Asynchronous reset mid-stream: outputs clear before any clock edge
        reset_n = 1'b0;
        #1;
        chk("async_rst_y", int'(y4), 0);
        chk("async_rst_cnt", int'(cnt4), 0);
        chk("async_rst_st", int'(st4), 0);
        chk("async_rst_sat_cnt", int'(cnts), 0);
        @(negedge clk);
        apply_reset();

        // Saturation with a 2-bit counter: 1111, eight ones, overlapping
        cyc(4'b1111, 1, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(4'b0000, 0, 1, 1, 1, 0);
            chk($sformatf("sat_bit%0d_cnt", i + 1), int'(cnts), (i < 3) ? 0 : ((i - 2 > 3) ? 3 : i - 2));
            chk($sformatf("sat_bit%0d_y", i + 1), int'(ys), (i < 3) ? 0 : 1);
            chk($sformatf("wide_bit%0d_cnt", i + 1), int'(cnt4), (i < 3) ? 0 : i - 2);
        end
        cyc(4'b0000, 0, 1, 1, 1, 1);
        chk("sat_clr_cnt", int'(cnts), 0);
        chk("sat_clr_y", int'(ys), 1);
        chk("sat_clr_st", int'(sts), 4);
        cyc(4'b0000, 0, 1, 1, 1, 0);
        chk("sat_after_clr_cnt", int'(cnts), 1);

        // Randomised run against the history model and legacy 01 detector
        apply_reset();
        ov_r = 1'b1;
        rp = 4'($urandom);
        cyc(rp, 1, 0, 0, ov_r, 0);
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 15) == 0) ov_r = ~ov_r;
            rp = 4'($urandom);
            cyc(rp, ($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)), ov_r, ($urandom_range(0, 99) == 0));
            chk("rand_st", int'(st4), ref_st(m_hist, m_hlen, m_pat));
            chk("rand_y", int'(y4), (ref_st(m_hist, m_hlen, m_pat) == 4) ? 1 : 0);
            chk("rand_cnt", int'(cnt4), m_cnt4);
            chk("rand_sat_cnt", int'(cnts), m_cnts);
            chk("leg_y", int'(yl), leg_y());
            chk("leg_cnt", int'(cntl), l_cnt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
